// File: rtl/rv_pkg.sv
// ---------------------------------------------------------------------------
// rv_pkg
// Shared types and constants for the RV64 operand-fetch / issue slice.
//   XLEN          : operand, immediate, pc and writeback data width
//   NREGS         : architectural register count (x0 hardwired zero)
//   reg_idx_t     : register index
//   xword_t       : XLEN-wide data word
//   opf_payload_t : operand-fetch to execute payload, shared with execute
// ---------------------------------------------------------------------------
package rv_pkg;

    localparam int unsigned XLEN   = 64;
    localparam int unsigned NREGS  = 32;
    localparam int unsigned RIDX_W = $clog2(NREGS);

    typedef logic [RIDX_W-1:0] reg_idx_t;
    typedef logic [XLEN-1:0]   xword_t;

    typedef struct packed {
        xword_t   rs1_value;
        xword_t   rs2_value;
        xword_t   imm;
        xword_t   pc;
        reg_idx_t rd;
        logic     wr_rd;
    } opf_payload_t;

    // x0 never participates in hazards or the scoreboard.
    function automatic logic idx_nz(input reg_idx_t idx);
        return idx != '0;
    endfunction

endpackage

// File: rtl/rv_scoreboard.sv
// ---------------------------------------------------------------------------
// rv_scoreboard
// Busy bit per architectural register (x1..x31), marking writes that have
// been handed to execute but not yet retired by writeback.
// Ports:
//   clk_i, rst_ni           : clock, asynchronous active-low reset
//   set_en_i, set_idx_i     : mark a register busy
//   clr_en_i, clr_idx_i     : retire a pending write
//   rs1/rs2/rd_idx_i        : combinational lookup indices
//   rs1/rs2/rd_busy_o       : busy state of the looked-up registers
// A set and clear of the same index in one cycle leaves the bit set.
// ---------------------------------------------------------------------------
module rv_scoreboard
    import rv_pkg::*;
(
    input  logic     clk_i,
    input  logic     rst_ni,
    input  logic     set_en_i,
    input  reg_idx_t set_idx_i,
    input  logic     clr_en_i,
    input  reg_idx_t clr_idx_i,
    input  reg_idx_t rs1_idx_i,
    input  reg_idx_t rs2_idx_i,
    input  reg_idx_t rd_idx_i,
    output logic     rs1_busy_o,
    output logic     rs2_busy_o,
    output logic     rd_busy_o
);

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;

    always_comb begin
        busy_d = busy_q;
        if (clr_en_i) begin
            busy_d[clr_idx_i] = 1'b0;
        end
        // Applied after the clear so a same-cycle set wins.
        if (set_en_i) begin
            busy_d[set_idx_i] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign rs1_busy_o = busy_q[rs1_idx_i];
    assign rs2_busy_o = busy_q[rs2_idx_i];
    assign rd_busy_o  = busy_q[rd_idx_i];

endmodule

// File: rtl/rv_operand_fetch.sv
// ---------------------------------------------------------------------------
// rv_operand_fetch
// Register-read / issue stage between decode and execute. Reads the regfile,
// stalls RAW and WAW hazards against a busy scoreboard and against the
// instruction held in the output register, and registers the operands for
// execute. Snoops the writeback bus to retire pending writes.
// Ports:
//   i_clk, i_resetn                    : clock, async active-low reset
//   i_dec_*, o_dec_ready               : decode offer / accept handshake
//   o_rf_rs1/rs2, i_rf_rs1/rs2_value   : combinational regfile read
//   o_ex_*, i_ex_ready                 : registered payload to execute
//   i_wb_valid, i_wb_rd, i_wb_data     : writeback bus (snooped only)
//   i_flush                            : squash the held instruction
// Build option:
//   RV_OPFETCH_WB_BYPASS_EN : forward same-cycle writeback data into the
//   operands and drop the scoreboard stall for the matching register.
// ---------------------------------------------------------------------------
module rv_operand_fetch
    import rv_pkg::*;
(
    input  logic     i_clk,
    input  logic     i_resetn,
    input  logic     i_dec_valid,
    output logic     o_dec_ready,
    input  reg_idx_t i_dec_rs1,
    input  reg_idx_t i_dec_rs2,
    input  reg_idx_t i_dec_rd,
    input  logic     i_dec_use_rs1,
    input  logic     i_dec_use_rs2,
    input  logic     i_dec_wr_rd,
    input  xword_t   i_dec_imm,
    input  xword_t   i_dec_pc,
    output reg_idx_t o_rf_rs1,
    output reg_idx_t o_rf_rs2,
    input  xword_t   i_rf_rs1_value,
    input  xword_t   i_rf_rs2_value,
    output logic     o_ex_valid,
    input  logic     i_ex_ready,
    output xword_t   o_ex_rs1_value,
    output xword_t   o_ex_rs2_value,
    output xword_t   o_ex_imm,
    output xword_t   o_ex_pc,
    output reg_idx_t o_ex_rd,
    output logic     o_ex_wr_rd,
    input  logic     i_wb_valid,
    input  reg_idx_t i_wb_rd,
    input  xword_t   i_wb_data,
    input  logic     i_flush
);

    opf_payload_t payload_q;
    opf_payload_t payload_d;
    logic         ex_valid_q;
    logic         ex_valid_d;

    logic rs1_busy, rs2_busy, rd_busy;
    logic wb_hit_rs1, wb_hit_rs2, wb_hit_rd;
    logic rs1_ex_hit, rs2_ex_hit, rd_ex_hit;
    logic rs1_haz, rs2_haz, rd_haz, hazard;
    logic handshake, accept, sb_set, sb_clr;
    xword_t rs1_val, rs2_val;

    assign o_rf_rs1 = i_dec_rs1;
    assign o_rf_rs2 = i_dec_rs2;

    // -------------------------------------------------------------------
    // Writeback bypass
    // -------------------------------------------------------------------
`ifdef RV_OPFETCH_WB_BYPASS_EN
    assign wb_hit_rs1 = i_wb_valid && idx_nz(i_wb_rd) && (i_wb_rd == i_dec_rs1);
    assign wb_hit_rs2 = i_wb_valid && idx_nz(i_wb_rd) && (i_wb_rd == i_dec_rs2);
    assign wb_hit_rd  = i_wb_valid && idx_nz(i_wb_rd) && (i_wb_rd == i_dec_rd);
`else
    logic wb_data_unused;
    assign wb_data_unused = ^i_wb_data;
    assign wb_hit_rs1 = 1'b0;
    assign wb_hit_rs2 = 1'b0;
    assign wb_hit_rd  = 1'b0;
`endif

    // -------------------------------------------------------------------
    // Hazard detection
    // -------------------------------------------------------------------
    // The held instruction's write is not yet in the scoreboard (it is set
    // on the downstream handshake), so it is matched directly.
    assign rs1_ex_hit = ex_valid_q && payload_q.wr_rd && (payload_q.rd == i_dec_rs1);
    assign rs2_ex_hit = ex_valid_q && payload_q.wr_rd && (payload_q.rd == i_dec_rs2);
    assign rd_ex_hit  = ex_valid_q && payload_q.wr_rd && (payload_q.rd == i_dec_rd);

    assign rs1_haz = i_dec_use_rs1 && idx_nz(i_dec_rs1)
                     && ((rs1_busy && !wb_hit_rs1) || rs1_ex_hit);
    assign rs2_haz = i_dec_use_rs2 && idx_nz(i_dec_rs2)
                     && ((rs2_busy && !wb_hit_rs2) || rs2_ex_hit);
    assign rd_haz  = i_dec_wr_rd && idx_nz(i_dec_rd)
                     && ((rd_busy && !wb_hit_rd) || rd_ex_hit);
    assign hazard  = rs1_haz || rs2_haz || rd_haz;

    assign o_dec_ready = i_resetn && !i_flush && (!ex_valid_q || i_ex_ready) && !hazard;
    assign accept      = i_dec_valid && o_dec_ready;
    assign handshake   = ex_valid_q && i_ex_ready;

    // -------------------------------------------------------------------
    // Operand select
    // -------------------------------------------------------------------
    always_comb begin
        rs1_val = '0;
        rs2_val = '0;
        if (i_dec_use_rs1 && idx_nz(i_dec_rs1)) begin
            rs1_val = wb_hit_rs1 ? i_wb_data : i_rf_rs1_value;
        end
        if (i_dec_use_rs2 && idx_nz(i_dec_rs2)) begin
            rs2_val = wb_hit_rs2 ? i_wb_data : i_rf_rs2_value;
        end
    end

    // -------------------------------------------------------------------
    // Output register
    // -------------------------------------------------------------------
    always_comb begin
        ex_valid_d = ex_valid_q;
        payload_d  = payload_q;
        if (i_flush) begin
            ex_valid_d = 1'b0;
        end else if (accept) begin
            ex_valid_d          = 1'b1;
            payload_d.rs1_value = rs1_val;
            payload_d.rs2_value = rs2_val;
            payload_d.imm       = i_dec_imm;
            payload_d.pc        = i_dec_pc;
            payload_d.rd        = i_dec_rd;
            payload_d.wr_rd     = i_dec_wr_rd;
        end else if (handshake) begin
            ex_valid_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            ex_valid_q <= 1'b0;
            payload_q  <= '0;
        end else begin
            ex_valid_q <= ex_valid_d;
            payload_q  <= payload_d;
        end
    end

    // -------------------------------------------------------------------
    // Scoreboard
    // -------------------------------------------------------------------
    // A flushed instruction never reaches execute, so it must not mark rd.
    assign sb_set = handshake && !i_flush && payload_q.wr_rd && idx_nz(payload_q.rd);
    assign sb_clr = i_wb_valid && idx_nz(i_wb_rd);

    rv_scoreboard u_scoreboard (
        .clk_i      (i_clk),
        .rst_ni     (i_resetn),
        .set_en_i   (sb_set),
        .set_idx_i  (payload_q.rd),
        .clr_en_i   (sb_clr),
        .clr_idx_i  (i_wb_rd),
        .rs1_idx_i  (i_dec_rs1),
        .rs2_idx_i  (i_dec_rs2),
        .rd_idx_i   (i_dec_rd),
        .rs1_busy_o (rs1_busy),
        .rs2_busy_o (rs2_busy),
        .rd_busy_o  (rd_busy)
    );

    assign o_ex_valid     = ex_valid_q;
    assign o_ex_rs1_value = payload_q.rs1_value;
    assign o_ex_rs2_value = payload_q.rs2_value;
    assign o_ex_imm       = payload_q.imm;
    assign o_ex_pc        = payload_q.pc;
    assign o_ex_rd        = payload_q.rd;
    assign o_ex_wr_rd     = payload_q.wr_rd;

endmodule

// File: tb/tb_rv_operand_fetch.sv
// ---------------------------------------------------------------------------
// tb_rv_operand_fetch
// Directed and randomized bench for rv_operand_fetch. A behavioural model
// (busy array, held-instruction record, regfile array) predicts o_dec_ready
// and the execute payload every cycle.
// ---------------------------------------------------------------------------
module tb_rv_operand_fetch;

    logic        i_clk;
    logic        i_resetn;
    logic        i_dec_valid;
    logic        o_dec_ready;
    logic [4:0]  i_dec_rs1, i_dec_rs2, i_dec_rd;
    logic        i_dec_use_rs1, i_dec_use_rs2, i_dec_wr_rd;
    logic [63:0] i_dec_imm, i_dec_pc;
    logic [4:0]  o_rf_rs1, o_rf_rs2;
    logic [63:0] i_rf_rs1_value, i_rf_rs2_value;
    logic        o_ex_valid;
    logic        i_ex_ready;
    logic [63:0] o_ex_rs1_value, o_ex_rs2_value, o_ex_imm, o_ex_pc;
    logic [4:0]  o_ex_rd;
    logic        o_ex_wr_rd;
    logic        i_wb_valid;
    logic [4:0]  i_wb_rd;
    logic [63:0] i_wb_data;
    logic        i_flush;

    rv_operand_fetch dut (
        .i_clk          (i_clk),
        .i_resetn       (i_resetn),
        .i_dec_valid    (i_dec_valid),
        .o_dec_ready    (o_dec_ready),
        .i_dec_rs1      (i_dec_rs1),
        .i_dec_rs2      (i_dec_rs2),
        .i_dec_rd       (i_dec_rd),
        .i_dec_use_rs1  (i_dec_use_rs1),
        .i_dec_use_rs2  (i_dec_use_rs2),
        .i_dec_wr_rd    (i_dec_wr_rd),
        .i_dec_imm      (i_dec_imm),
        .i_dec_pc       (i_dec_pc),
        .o_rf_rs1       (o_rf_rs1),
        .o_rf_rs2       (o_rf_rs2),
        .i_rf_rs1_value (i_rf_rs1_value),
        .i_rf_rs2_value (i_rf_rs2_value),
        .o_ex_valid     (o_ex_valid),
        .i_ex_ready     (i_ex_ready),
        .o_ex_rs1_value (o_ex_rs1_value),
        .o_ex_rs2_value (o_ex_rs2_value),
        .o_ex_imm       (o_ex_imm),
        .o_ex_pc        (o_ex_pc),
        .o_ex_rd        (o_ex_rd),
        .o_ex_wr_rd     (o_ex_wr_rd),
        .i_wb_valid     (i_wb_valid),
        .i_wb_rd        (i_wb_rd),
        .i_wb_data      (i_wb_data),
        .i_flush        (i_flush)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Regfile model, written by the bench when writeback retires.
    logic [63:0] rf [32];
    assign i_rf_rs1_value = rf[o_rf_rs1];
    assign i_rf_rs2_value = rf[o_rf_rs2];

    // Reference state: pending-write set and the instruction held for execute.
    bit          mb [32];
    bit          mv;
    logic [63:0] m_rs1v, m_rs2v, m_imm, m_pc;
    logic [4:0]  m_rd;
    bit          m_wr;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [261:0] got, input logic [261:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [261:0] dut_pl();
        return {o_ex_rs1_value, o_ex_rs2_value, o_ex_imm, o_ex_pc, o_ex_rd, o_ex_wr_rd};
    endfunction

    function automatic logic [261:0] mdl_pl();
        return {m_rs1v, m_rs2v, m_imm, m_pc, m_rd, m_wr};
    endfunction

    function automatic bit byp(input logic [4:0] s);
`ifdef RV_OPFETCH_WB_BYPASS_EN
        return i_wb_valid && (i_wb_rd == s) && (s != 0);
`else
        return (s != s);
`endif
    endfunction

    function automatic bit haz(input logic [4:0] s, input bit used);
        if (!used || s == 0) return 1'b0;
        if (mb[s] && !byp(s)) return 1'b1;
        return mv && m_wr && (m_rd == s);
    endfunction

    function automatic logic [63:0] opval(input logic [4:0] s, input bit used);
        if (!used || s == 0) return 64'd0;
        if (byp(s)) return i_wb_data;
        return rf[s];
    endfunction

    function automatic bit exp_ready();
        if (!i_resetn || i_flush) return 1'b0;
        if (mv && !i_ex_ready) return 1'b0;
        return !(haz(i_dec_rs1, i_dec_use_rs1) || haz(i_dec_rs2, i_dec_use_rs2)
                 || haz(i_dec_rd, i_dec_wr_rd));
    endfunction

    task automatic mreset();
        for (int i = 0; i < 32; i++) mb[i] = 1'b0;
        mv = 1'b0; m_rs1v = '0; m_rs2v = '0; m_imm = '0; m_pc = '0; m_rd = '0; m_wr = 1'b0;
    endtask

    task automatic dec(input bit v, input logic [4:0] rs1, input bit u1,
                       input logic [4:0] rs2, input bit u2,
                       input logic [4:0] rd, input bit wr, input logic [63:0] imm);
        i_dec_valid = v; i_dec_rs1 = rs1; i_dec_use_rs1 = u1;
        i_dec_rs2 = rs2; i_dec_use_rs2 = u2; i_dec_rd = rd; i_dec_wr_rd = wr;
        i_dec_imm = imm; i_dec_pc = 64'h1000 + (imm << 2);
    endtask

    task automatic wb(input bit v, input logic [4:0] rd, input logic [63:0] d);
        i_wb_valid = v; i_wb_rd = rd; i_wb_data = d;
    endtask

    // One clock: check combinational outputs, advance the model across the
    // edge, then check registered outputs. An accepted offer is withdrawn.
    task automatic cycle();
        bit r, acc, hs;
        logic [63:0] n1, n2;
        #1;
        r = exp_ready();
        check("dec_ready", o_dec_ready, r);
        check("rf_addr", {o_rf_rs1, o_rf_rs2}, {i_dec_rs1, i_dec_rs2});
        acc = i_dec_valid && r;
        hs  = mv && i_ex_ready && !i_flush;
        n1  = opval(i_dec_rs1, i_dec_use_rs1);
        n2  = opval(i_dec_rs2, i_dec_use_rs2);
        @(posedge i_clk);
        #1;
        if (i_wb_valid && i_wb_rd != 0) begin
            mb[i_wb_rd] = 1'b0;
            rf[i_wb_rd] = i_wb_data;
        end
        if (hs && m_wr && m_rd != 0) mb[m_rd] = 1'b1;
        if (i_flush) mv = 1'b0;
        else if (acc) begin
            mv = 1'b1; m_rs1v = n1; m_rs2v = n2; m_imm = i_dec_imm;
            m_pc = i_dec_pc; m_rd = i_dec_rd; m_wr = i_dec_wr_rd;
        end else if (hs) mv = 1'b0;
        check("ex_valid", o_ex_valid, mv);
        check("ex_payload", dut_pl(), mdl_pl());
        if (acc) i_dec_valid = 1'b0;
    endtask

    task automatic retire(input logic [4:0] rd, input logic [63:0] d);
        wb(1'b1, rd, d);
        cycle();
        wb(1'b0, 5'd0, 64'd0);
    endtask

    task automatic wait_issue(input string tag);
        int n = 0;
        while (i_dec_valid && n < 16) begin
            cycle();
            n++;
        end
        if (i_dec_valid) begin
            total++;
            bad++;
            $error("FAIL %s observed=stalled expected=issued", tag);
        end
    endtask

    initial begin
        i_resetn = 1'b0; i_ex_ready = 1'b0; i_flush = 1'b0;
        dec(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 64'd0);
        wb(1'b0, 5'd0, 64'd0);
        rf[0] = 64'd0;
        for (int i = 1; i < 32; i++) rf[i] = {$urandom, $urandom};
        mreset();

        // Reset state
        repeat (2) @(posedge i_clk);
        #1;
        check("rst_ready", o_dec_ready, 1'b0);
        check("rst_valid", o_ex_valid, 1'b0);
        check("rst_payload", dut_pl(), 262'd0);
        i_resetn   = 1'b1;
        i_ex_ready = 1'b1;

        // addi x5, x0, 7
        dec(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 64'd7);
        cycle();
        check("addi_fields", {o_ex_valid, o_ex_rs1_value, o_ex_imm, o_ex_rd},
              {1'b1, 64'd0, 64'd7, 5'd5});

        // RAW on x5
        dec(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 64'h10);
        cycle();
        cycle();
        check("raw_stall", o_dec_ready, 1'b0);
        retire(5'd5, 64'h55);
`ifdef RV_OPFETCH_WB_BYPASS_EN
        check("raw_byp_issue", {o_ex_valid, o_ex_rs1_value}, {1'b1, 64'h55});
`else
        check("raw_wait", o_ex_valid, 1'b0);
        cycle();
        check("raw_issue", {o_ex_valid, o_ex_rs1_value}, {1'b1, 64'h55});
`endif
        cycle();
        retire(5'd6, 64'h66);

        // WAW on x3
        dec(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 64'd1);
        cycle();
        dec(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 64'd2);
        cycle();
        cycle();
        check("waw_stall", o_dec_ready, 1'b0);
        retire(5'd3, 64'h33);
`ifndef RV_OPFETCH_WB_BYPASS_EN
        cycle();
`endif
        check("waw_issue", {o_ex_valid, o_ex_rd, o_ex_imm}, {1'b1, 5'd3, 64'd2});

        // Same-cycle set and clear of x3: set must win
        retire(5'd3, 64'h34);
        dec(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 64'd3);
        #1;
        check("set_wins", o_dec_ready, 1'b0);
        cycle();
        retire(5'd3, 64'h35);
        wait_issue("x3_reader");
        check("x3_value", o_ex_rs1_value, 64'h35);
        cycle();

        // Backpressure
        dec(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd10, 1'b1, 64'hA);
        cycle();
        i_ex_ready = 1'b0;
        dec(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 5'd11, 1'b1, 64'hB);
        repeat (4) begin
            cycle();
            check("bp_ready", o_dec_ready, 1'b0);
            check("bp_payload",
                  {o_ex_valid, o_ex_rs1_value, o_ex_rs2_value, o_ex_imm, o_ex_pc, o_ex_rd},
                  {1'b1, rf[1], rf[2], 64'hA, 64'h1028, 5'd10});
        end
        i_ex_ready = 1'b1;
        cycle();
        check("bp_release", {o_ex_valid, o_ex_rd, o_ex_imm}, {1'b1, 5'd11, 64'hB});
        cycle();
        retire(5'd10, 64'hA0);
        retire(5'd11, 64'hB0);

        // Flush of a held write to x7
        dec(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 64'h7);
        cycle();
        dec(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 64'h8);
        i_flush = 1'b1;
        cycle();
        i_flush = 1'b0;
        check("flush_valid", o_ex_valid, 1'b0);
        cycle();
        check("flush_no_busy", {o_ex_valid, o_ex_rd}, {1'b1, 5'd8});
        cycle();
        retire(5'd8, 64'h88);

        // Asynchronous reset during a stall on x9
        dec(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 64'h9);
        cycle();
        dec(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd12, 1'b1, 64'hC);
        cycle();
        cycle();
        check("arst_pre_stall", o_dec_ready, 1'b0);
        #2 i_resetn = 1'b0;
        #1;
        mreset();
        check("arst_valid", o_ex_valid, 1'b0);
        check("arst_payload", dut_pl(), 262'd0);
        check("arst_ready", o_dec_ready, 1'b0);
        #1 i_resetn = 1'b1;
        cycle();
        check("arst_reader", {o_ex_valid, o_ex_rd}, {1'b1, 5'd12});
        cycle();

        // Randomized traffic on a small register window to provoke hazards
        for (int n = 0; n < 400; n++) begin
            dec($urandom_range(0, 3) != 0,
                5'($urandom_range(0, 7)), $urandom_range(0, 1) != 0,
                5'($urandom_range(0, 7)), $urandom_range(0, 1) != 0,
                5'($urandom_range(0, 7)), $urandom_range(0, 1) != 0,
                {$urandom, $urandom});
            i_dec_pc   = {$urandom, $urandom};
            i_ex_ready = $urandom_range(0, 3) != 0;
            i_flush    = $urandom_range(0, 15) == 0;
            wb($urandom_range(0, 1) != 0, 5'($urandom_range(0, 7)), {$urandom, $urandom});
            cycle();
        end
        i_flush = 1'b0;
        wb(1'b0, 5'd0, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
